// File: rtl/fetch_sequencer.sv
// Fetch/decode/execute controller that owns PC, IR and ACC and sequences the
// MAR and RAM strobes on a shared tri-state system bus.
module fetch_sequencer #(
    parameter int                   BUS_WIDTH    = 16,
    parameter logic [BUS_WIDTH-1:0] RESET_VECTOR = '0,
    parameter int                   ADDR_FIELD   = 12
) (
    input  logic                 clk,
    input  logic                 rst_n,
    inout  wire  [BUS_WIDTH-1:0] bus,
    input  logic                 run,
    output logic                 mar_oe,
    output logic                 mar_le,
    output logic                 ram_oe,
    output logic                 ram_we,
    output logic                 halted,
    output logic [BUS_WIDTH-1:0] pc,
    output logic [BUS_WIDTH-1:0] ir,
    output logic [BUS_WIDTH-1:0] acc
);

    // state  | meaning
    // IDLE   | waiting for run after reset
    // F_ADDR | drive PC onto bus, MAR latches it
    // F_READ | RAM drives instruction, IR captures it, PC increments
    // DECODE | dispatch on opcode; JUMP reloads PC here
    // E_ADDR | drive operand address onto bus, MAR latches it
    // E_MEM  | LOAD/ADD read RAM into ACC, STORE drives ACC and writes RAM
    // HALT   | parked until run
    typedef enum logic [2:0] {
        S_IDLE, S_F_ADDR, S_F_READ, S_DECODE, S_E_ADDR, S_E_MEM, S_HALT
    } state_t;

    localparam logic [3:0] OP_LOAD  = 4'h1;
    localparam logic [3:0] OP_STORE = 4'h2;
    localparam logic [3:0] OP_JUMP  = 4'h3;
    localparam logic [3:0] OP_ADD   = 4'h4;
    localparam logic [3:0] OP_HALT  = 4'hF;

    state_t               state_q, state_d;
    logic [BUS_WIDTH-1:0] pc_q, pc_d;
    logic [BUS_WIDTH-1:0] ir_q, ir_d;
    logic [BUS_WIDTH-1:0] acc_q, acc_d;

    logic [3:0]           opcode;
    logic [BUS_WIDTH-1:0] op_addr;
    logic                 drv_en;
    logic [BUS_WIDTH-1:0] drv_val;

    assign opcode  = ir_q[BUS_WIDTH-1 -: 4];
    assign op_addr = {{(BUS_WIDTH-ADDR_FIELD){1'b0}}, ir_q[ADDR_FIELD-1:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_VECTOR;
            ir_q    <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            acc_q   <= acc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        acc_d   = acc_q;
        unique case (state_q)
            S_IDLE:   if (run) state_d = S_F_ADDR;
            S_F_ADDR: state_d = S_F_READ;
            S_F_READ: begin
                ir_d    = bus;
                pc_d    = pc_q + 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                case (opcode)
                    OP_JUMP: begin
                        pc_d    = op_addr;
                        state_d = S_F_ADDR;
                    end
                    OP_HALT:                  state_d = S_HALT;
                    OP_LOAD, OP_STORE, OP_ADD: state_d = S_E_ADDR;
                    default:                  state_d = S_F_ADDR;
                endcase
            end
            S_E_ADDR: state_d = S_E_MEM;
            S_E_MEM: begin
                if (opcode == OP_LOAD) acc_d = bus;
                else if (opcode == OP_ADD) acc_d = acc_q + bus;
                state_d = S_F_ADDR;
            end
            S_HALT:   if (run) state_d = S_F_ADDR;
            default:  state_d = S_IDLE;
        endcase
    end

    // Moore decode: async reset forces IDLE, so ram_we and bus drive drop at once.
    always_comb begin
        mar_le  = 1'b0;
        ram_oe  = 1'b0;
        ram_we  = 1'b0;
        halted  = 1'b0;
        drv_en  = 1'b0;
        drv_val = '0;
        unique case (state_q)
            S_F_ADDR: begin
                mar_le  = 1'b1;
                drv_en  = 1'b1;
                drv_val = pc_q;
            end
            S_F_READ: ram_oe = 1'b1;
            S_E_ADDR: begin
                mar_le  = 1'b1;
                drv_en  = 1'b1;
                drv_val = op_addr;
            end
            S_E_MEM: begin
                if (opcode == OP_STORE) begin
                    ram_we  = 1'b1;
                    drv_en  = 1'b1;
                    drv_val = acc_q;
                end else begin
                    ram_oe = 1'b1;
                end
            end
            S_HALT:  halted = 1'b1;
            default: ;
        endcase
    end

    assign bus    = drv_en ? drv_val : {BUS_WIDTH{1'bz}};
    assign mar_oe = 1'b1;
    assign pc     = pc_q;
    assign ir     = ir_q;
    assign acc    = acc_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a small MAR/RAM model on the bus;
// a second instance with RESET_VECTOR=0xFFFF exercises PC wrap.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0;
    wire  [15:0] bus;
    logic        mar_oe, mar_le, ram_oe, ram_we, halted;
    logic [15:0] pc, ir, acc;

    logic        rst2_n = 1'b0;
    logic        run2 = 1'b0;
    wire  [15:0] bus2;
    logic        mar_oe2, mar_le2, ram_oe2, ram_we2, halted2;
    logic [15:0] pc2, ir2, acc2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fetch_sequencer #(.BUS_WIDTH(16), .RESET_VECTOR(16'h0000), .ADDR_FIELD(12)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus), .run(run),
        .mar_oe(mar_oe), .mar_le(mar_le), .ram_oe(ram_oe), .ram_we(ram_we),
        .halted(halted), .pc(pc), .ir(ir), .acc(acc)
    );

    fetch_sequencer #(.BUS_WIDTH(16), .RESET_VECTOR(16'hFFFF), .ADDR_FIELD(12)) dut_wrap (
        .clk(clk), .rst_n(rst2_n), .bus(bus2), .run(run2),
        .mar_oe(mar_oe2), .mar_le(mar_le2), .ram_oe(ram_oe2), .ram_we(ram_we2),
        .halted(halted2), .pc(pc2), .ir(ir2), .acc(acc2)
    );

    // RAM + MAR model; the bench preloads words through the ld_* port
    logic [15:0] mem [0:255];
    logic [15:0] mar = '0;
    logic        ld_en = 1'b0;
    logic [7:0]  ld_addr = '0;
    logic [15:0] ld_data = '0;

    always @(posedge clk) begin
        if (ld_en) mem[ld_addr] <= ld_data;
        else if (ram_we) mem[mar[7:0]] <= bus;
        if (mar_le) mar <= bus;
    end
    assign bus = ram_oe ? mem[mar[7:0]] : 16'bz;

    // wrap instance sees NOP at 0xFFFF and HALT everywhere else
    logic [15:0] mar2 = '0;
    always @(posedge clk) if (mar_le2) mar2 <= bus2;
    assign bus2 = ram_oe2 ? ((mar2 == 16'hFFFF) ? 16'h0000 : 16'hF000) : 16'bz;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic ld(input logic [7:0] a, input logic [15:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        step(1);
        ld_en = 1'b0;
    endtask

    task automatic start_run();
        run = 1'b1;
        step(1);
        run = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(2);
        checks++; if (mar_oe !== 1'b1 || mar_le !== 1'b0 || ram_oe !== 1'b0 || ram_we !== 1'b0 || halted !== 1'b0) begin
            errors++; $display("FAIL reset_strobes: got oe=%b le=%b roe=%b we=%b h=%b want 1 0 0 0 0", mar_oe, mar_le, ram_oe, ram_we, halted);
        end
        checks++; if (pc !== 16'h0000 || ir !== 16'h0000 || acc !== 16'h0000) begin
            errors++; $display("FAIL reset_regs: got pc=%h ir=%h acc=%h want 0000 0000 0000", pc, ir, acc);
        end
    endtask

    task automatic test_reset_mid_store();
        rst_n = 1'b0;
        ld(8'h00, 16'h1010); ld(8'h01, 16'h2012);
        ld(8'h10, 16'h1234); ld(8'h12, 16'hAAAA);
        rst_n = 1'b1;
        start_run();
        step(9);
        checks++; if (ram_we !== 1'b1 || bus !== 16'h1234) begin
            errors++; $display("FAIL store_emem: got we=%b bus=%h want 1 1234", ram_we, bus);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (ram_we !== 1'b0 || mar_le !== 1'b0 || ram_oe !== 1'b0) begin
            errors++; $display("FAIL reset_we_drop: got we=%b le=%b roe=%b want 0 0 0", ram_we, mar_le, ram_oe);
        end
        checks++; if (pc !== 16'h0000 || acc !== 16'h0000) begin
            errors++; $display("FAIL reset_mid_regs: got pc=%h acc=%h want 0000 0000", pc, acc);
        end
        step(2);
        checks++; if (mem[8'h12] !== 16'hAAAA) begin
            errors++; $display("FAIL reset_no_write: got mem12=%h want aaaa", mem[8'h12]);
        end
    endtask

    task automatic test_fetch_nop();
        rst_n = 1'b0;
        ld(8'h00, 16'h0000); ld(8'h01, 16'hF000);
        rst_n = 1'b1;
        start_run();
        checks++; if (mar_le !== 1'b1 || bus !== 16'h0000) begin
            errors++; $display("FAIL fetch_addr: got le=%b bus=%h want 1 0000", mar_le, bus);
        end
        step(1);
        checks++; if (ram_oe !== 1'b1 || mar_le !== 1'b0 || bus !== 16'h0000) begin
            errors++; $display("FAIL fetch_read: got roe=%b le=%b bus=%h want 1 0 0000", ram_oe, mar_le, bus);
        end
        step(1);
        checks++; if (ir !== 16'h0000 || pc !== 16'h0001) begin
            errors++; $display("FAIL fetch_ir: got ir=%h pc=%h want 0000 0001", ir, pc);
        end
        step(3);
        checks++; if (halted !== 1'b0) begin
            errors++; $display("FAIL halt_early: got halted=%b want 0", halted);
        end
        step(1);
        checks++; if (halted !== 1'b1 || pc !== 16'h0002 || ir !== 16'hF000) begin
            errors++; $display("FAIL halt_nop: got h=%b pc=%h ir=%h want 1 0002 f000", halted, pc, ir);
        end
    endtask

    task automatic test_load_add_store();
        rst_n = 1'b0;
        ld(8'h00, 16'h1010); ld(8'h01, 16'h4011); ld(8'h02, 16'h2012); ld(8'h03, 16'hF000);
        ld(8'h10, 16'h7FFF); ld(8'h11, 16'h0003); ld(8'h12, 16'h0000);
        rst_n = 1'b1;
        start_run();
        step(17);
        checks++; if (halted !== 1'b0) begin
            errors++; $display("FAIL las_halt_early: got halted=%b want 0", halted);
        end
        step(1);
        checks++; if (halted !== 1'b1 || acc !== 16'h8002) begin
            errors++; $display("FAIL las_acc: got h=%b acc=%h want 1 8002", halted, acc);
        end
        checks++; if (mem[8'h12] !== 16'h8002 || pc !== 16'h0004) begin
            errors++; $display("FAIL las_store: got mem12=%h pc=%h want 8002 0004", mem[8'h12], pc);
        end
    endtask

    task automatic test_add_overflow();
        rst_n = 1'b0;
        ld(8'h00, 16'h1010); ld(8'h01, 16'h4011); ld(8'h02, 16'hF000);
        ld(8'h10, 16'hFFFF); ld(8'h11, 16'h0002);
        rst_n = 1'b1;
        start_run();
        step(5);
        checks++; if (acc !== 16'hFFFF) begin
            errors++; $display("FAIL ovf_load: got acc=%h want ffff", acc);
        end
        step(8);
        checks++; if (acc !== 16'h0001 || halted !== 1'b1) begin
            errors++; $display("FAIL ovf_add: got acc=%h h=%b want 0001 1", acc, halted);
        end
        // resume from HALT runs the word after it
        ld(8'h03, 16'hF000);
        start_run();
        checks++; if (mar_le !== 1'b1 || bus !== 16'h0003 || halted !== 1'b0) begin
            errors++; $display("FAIL resume: got le=%b bus=%h h=%b want 1 0003 0", mar_le, bus, halted);
        end
    endtask

    task automatic test_pc_wrap();
        rst2_n = 1'b1;
        run2 = 1'b1;
        step(1);
        run2 = 1'b0;
        checks++; if (mar_le2 !== 1'b1 || bus2 !== 16'hFFFF) begin
            errors++; $display("FAIL wrap_addr: got le=%b bus=%h want 1 ffff", mar_le2, bus2);
        end
        step(2);
        checks++; if (pc2 !== 16'h0000 || ir2 !== 16'h0000) begin
            errors++; $display("FAIL wrap_pc: got pc=%h ir=%h want 0000 0000", pc2, ir2);
        end
        step(1);
        checks++; if (mar_le2 !== 1'b1 || bus2 !== 16'h0000) begin
            errors++; $display("FAIL wrap_next: got le=%b bus=%h want 1 0000", mar_le2, bus2);
        end
    endtask

    task automatic test_jump_loop();
        rst_n = 1'b0;
        for (int i = 0; i < 5; i++) ld(8'(i), 16'h0000);
        ld(8'h05, 16'h3005);
        rst_n = 1'b1;
        start_run();
        step(15);
        checks++; if (mar_le !== 1'b1 || bus !== 16'h0005) begin
            errors++; $display("FAIL loop_entry: got le=%b bus=%h want 1 0005", mar_le, bus);
        end
        for (int k = 0; k < 3; k++) begin
            step(2);
            checks++; if (mar_le !== 1'b0 || pc !== 16'h0006) begin
                errors++; $display("FAIL loop_decode: got le=%b pc=%h want 0 0006", mar_le, pc);
            end
            step(1);
            checks++; if (mar_le !== 1'b1 || bus !== 16'h0005 || pc !== 16'h0005) begin
                errors++; $display("FAIL loop_faddr: got le=%b bus=%h pc=%h want 1 0005 0005", mar_le, bus, pc);
            end
        end
    endtask

    task automatic test_bus_exclusive();
        logic [15:0] w;
        rst_n = 1'b0;
        for (int i = 0; i < 16; i++) begin
            case ($urandom_range(0, 4))
                0: w = 16'h0000;
                1: w = 16'h1020 | 16'($urandom_range(0, 15));
                2: w = 16'h2020 | 16'($urandom_range(0, 15));
                3: w = 16'h3000 | 16'($urandom_range(0, 15));
                default: w = 16'h4020 | 16'($urandom_range(0, 15));
            endcase
            ld(8'(i), w);
        end
        for (int i = 0; i < 16; i++) ld(8'(8'h20 + i), 16'($urandom));
        rst_n = 1'b1;
        start_run();
        for (int c = 0; c < 300; c++) begin
            checks++; if ((ram_oe & ram_we) !== 1'b0 || (mar_le & ram_we) !== 1'b0 || (ram_oe & mar_le) !== 1'b0) begin
                errors++; $display("FAIL excl_strobes: cyc=%0d got roe=%b we=%b le=%b want no overlap", c, ram_oe, ram_we, mar_le);
            end
            if (ram_oe === 1'b1) begin
                checks++; if (bus !== mem[mar[7:0]]) begin
                    errors++; $display("FAIL excl_bus: cyc=%0d got bus=%h want ram %h", c, bus, mem[mar[7:0]]);
                end
            end
            step(1);
        end
    endtask

    initial begin
        step(1);
        test_reset();
        test_reset_mid_store();
        test_fetch_nop();
        test_load_add_store();
        test_add_overflow();
        test_pc_wrap();
        test_jump_loop();
        test_bus_exclusive();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
